fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the in-order pipeline. It tracks in-flight destination writes in an internal shift pipeline of DEPTH stages past EX, issues a registered forward select per source operand for the instruction entering EX, and raises a stall on load-use hazards. It sits between ID and EX, drives the EX operand muxes and the ID/IF hold logic, and extends the fixed 2-stage, 2-source scheme to any depth, source count and load latency.

---
 rtl/fwd_pkg.sv | 27 ++
 rtl/fwd_src_match.sv | 41 ++++
 rtl/fwd_hazard_unit.sv | 116 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

    // Widest supported register address; narrower addresses are zero-extended into entries.
    localparam int RD_MAX_W    = 8;
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                wen;
        logic                is_load;
    } fwd_entry_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// One source operand against the in-flight entries: youngest matching stage,
// whether any match exists, and whether that producer's data is forwardable.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0]     i_src,
    input  logic                      i_used,
    input  logic [DEPTH-1:0]          i_valid,
    input  logic [DEPTH-1:0]          i_wen,
    input  logic [DEPTH-1:0]          i_is_load,
    input  logic [DEPTH*RD_MAX_W-1:0] i_rd,
    output logic [SEL_W-1:0]          o_idx,
    output logic                      o_found,
    output logic                      o_ready
);

    logic [RD_MAX_W-1:0] w_src;

    assign w_src = RD_MAX_W'(i_src);

    // Scan oldest to youngest so the lowest matching stage wins; older matches are never used.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        o_ready = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (i_used && (w_src != '0) && i_valid[s] && i_wen[s] &&
                (i_rd[s*RD_MAX_W +: RD_MAX_W] == w_src)) begin
                o_idx   = SEL_W'(s);
                o_found = 1'b1;
                o_ready = !i_is_load[s] || (s >= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for the instruction entering EX,
// tracking in-flight destination writes over DEPTH stages past EX.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int  REG_ADDR_W = 5,
    parameter int  NUM_SRC    = 2,
    parameter int  DEPTH      = 2,
    parameter int  LOAD_LAT   = 1,
    parameter int  CNT_W      = 16,
    localparam int SEL_W      = clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_wen,
    input  logic                          id_is_load,
    input  logic                          hold,
    input  logic                          flush,
    output logic                          stall,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          ex_valid,
    output logic [CNT_W-1:0]              stall_count
);

    if (LOAD_LAT > DEPTH - 1) begin : g_bad_load_lat
        $error("fwd_hazard_unit: LOAD_LAT must not exceed DEPTH-1");
    end

    // Stage DEPTH is never forwardable, so only stages 0..DEPTH-1 are kept.
    fwd_entry_t               r_ent [DEPTH];
    logic [NUM_SRC*SEL_W-1:0] r_fwd_sel;
    logic [CNT_W-1:0]         r_cnt;

    logic [DEPTH-1:0]          w_valid;
    logic [DEPTH-1:0]          w_wen;
    logic [DEPTH-1:0]          w_is_load;
    logic [DEPTH*RD_MAX_W-1:0] w_rd;
    logic [NUM_SRC-1:0]        w_found;
    logic [NUM_SRC-1:0]        w_ready;
    logic [SEL_W-1:0]          w_idx [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0]  w_next_sel;
    logic                      w_hazard;
    logic                      w_issue;

    for (genvar s = 0; s < DEPTH; s++) begin : g_flat
        assign w_valid[s]                       = r_ent[s].valid;
        assign w_wen[s]                         = r_ent[s].wen;
        assign w_is_load[s]                     = r_ent[s].is_load;
        assign w_rd[s*RD_MAX_W +: RD_MAX_W]     = r_ent[s].rd;
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .LOAD_LAT   (LOAD_LAT),
            .SEL_W      (SEL_W)
        ) u_match (
            .i_src     (id_src[i*REG_ADDR_W +: REG_ADDR_W]),
            .i_used    (id_src_used[i]),
            .i_valid   (w_valid),
            .i_wen     (w_wen),
            .i_is_load (w_is_load),
            .i_rd      (w_rd),
            .o_idx     (w_idx[i]),
            .o_found   (w_found[i]),
            .o_ready   (w_ready[i])
        );

        // Entry at current stage s will sit at stage s+1 once the consumer reaches EX.
        assign w_next_sel[i*SEL_W +: SEL_W] = (w_found[i] && w_ready[i])
                                            ? w_idx[i] + SEL_W'(1)
                                            : SEL_W'(SEL_REGFILE);
    end

    assign w_hazard = |(w_found & ~w_ready);
    assign stall    = id_valid && !flush && w_hazard;
    assign w_issue  = id_valid && !stall && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_ent[s] <= '0;
            end
            r_fwd_sel <= '0;
            r_cnt     <= '0;
        end else if (hold) begin
            // Frozen pipeline: a redirect can still kill whatever sits in EX.
            if (flush) begin
                r_ent[0].valid <= 1'b0;
                r_fwd_sel      <= '0;
            end
        end else begin
            r_ent[0] <= '{valid: w_issue, rd: RD_MAX_W'(id_rd), wen: id_wen, is_load: id_is_load};
            for (int s = 1; s < DEPTH; s++) begin
                r_ent[s] <= r_ent[s-1];
                if (s == 1 && flush) begin
                    r_ent[s].valid <= 1'b0;
                end
            end
            r_fwd_sel <= w_issue ? w_next_sel : '0;
            if (stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign fwd_sel     = r_fwd_sel;
    assign ex_valid    = r_ent[0].valid;
    assign stall_count = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default DEPTH=2/LOAD_LAT=1 instance plus a
// DEPTH=3/LOAD_LAT=2 instance with a 2-bit stall counter for saturation.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        a_valid, a_wen, a_ld, a_hold, a_flush, a_stall, a_exv;
    logic [9:0]  a_src;
    logic [1:0]  a_used;
    logic [4:0]  a_rd;
    logic [3:0]  a_sel;
    logic [15:0] a_cnt;

    logic        b_valid, b_wen, b_ld, b_hold, b_flush, b_stall, b_exv;
    logic [9:0]  b_src;
    logic [1:0]  b_used;
    logic [4:0]  b_rd;
    logic [3:0]  b_sel;
    logic [1:0]  b_cnt;

    fwd_hazard_unit u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (a_valid),
        .id_src      (a_src),
        .id_src_used (a_used),
        .id_rd       (a_rd),
        .id_wen      (a_wen),
        .id_is_load  (a_ld),
        .hold        (a_hold),
        .flush       (a_flush),
        .stall       (a_stall),
        .fwd_sel     (a_sel),
        .ex_valid    (a_exv),
        .stall_count (a_cnt)
    );

    fwd_hazard_unit #(
        .DEPTH    (3),
        .LOAD_LAT (2),
        .CNT_W    (2)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (b_valid),
        .id_src      (b_src),
        .id_src_used (b_used),
        .id_rd       (b_rd),
        .id_wen      (b_wen),
        .id_is_load  (b_ld),
        .hold        (b_hold),
        .flush       (b_flush),
        .stall       (b_stall),
        .fwd_sel     (b_sel),
        .ex_valid    (b_exv),
        .stall_count (b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                           input logic [1:0] used, input logic [4:0] rd,
                           input logic wen, input logic ld);
        a_valid = v;
        a_src   = {s1, s0};
        a_used  = used;
        a_rd    = rd;
        a_wen   = wen;
        a_ld    = ld;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] s0, input logic [1:0] used,
                           input logic [4:0] rd, input logic wen, input logic ld);
        b_valid = v;
        b_src   = {5'd0, s0};
        b_used  = used;
        b_rd    = rd;
        b_wen   = wen;
        b_ld    = ld;
    endtask

    task automatic idle_a(input int n);
        drive_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic idle_b(input int n);
        drive_b(1'b0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        drive_a(1'b1, 5'd5, 5'd5, 2'b11, 5'd1, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #2;
        checks++; if (a_sel !== 4'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", a_sel); end
        checks++; if (a_exv !== 1'b0) begin errors++; $display("FAIL reset_exv: got %0b want 0", a_exv); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", a_stall); end
        checks++; if (b_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt_b: got %0d want 0", b_cnt); end
        tick();
        tick();
        rst = 1'b0;
        idle_a(1);
    endtask

    task automatic test_alu_b2b();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL b2b_prod_stall: got %0b want 0", a_stall); end
        tick();
        checks++; if (a_exv !== 1'b1) begin errors++; $display("FAIL b2b_prod_exv: got %0b want 1", a_exv); end
        drive_a(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL b2b_use_stall: got %0b want 0", a_stall); end
        tick();
        checks++; if (a_sel !== 4'b0001) begin errors++; $display("FAIL b2b_sel: got %b want 0001", a_sel); end
        checks++; if (a_exv !== 1'b1) begin errors++; $display("FAIL b2b_exv: got %0b want 1", a_exv); end
        idle_a(3);
    endtask

    task automatic test_distance();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
        tick();
        idle_a(1);
        drive_a(1'b1, 5'd1, 5'd3, 2'b11, 5'd0, 1'b0, 1'b0);
        tick();
        checks++; if (a_sel !== 4'b1000) begin errors++; $display("FAIL dist1_sel: got %b want 1000", a_sel); end
        idle_a(3);
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
        tick();
        idle_a(2);
        drive_a(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        tick();
        checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL dist3_sel: got %b want 0000", a_sel); end
        checks++; if (a_exv !== 1'b1) begin errors++; $display("FAIL dist3_exv: got %0b want 1", a_exv); end
        idle_a(3);
    endtask

    task automatic test_load_use();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %0b want 1", a_stall); end
        tick();
        checks++; if (a_exv !== 1'b0) begin errors++; $display("FAIL lu_bubble_exv: got %0b want 0", a_exv); end
        checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL lu_bubble_sel: got %b want 0000", a_sel); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", a_cnt); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_stall2: got %0b want 0", a_stall); end
        tick();
        checks++; if (a_sel !== 4'b0010) begin errors++; $display("FAIL lu_sel: got %b want 0010", a_sel); end
        checks++; if (a_exv !== 1'b1) begin errors++; $display("FAIL lu_exv: got %0b want 1", a_exv); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold: got %0d want 1", a_cnt); end
        idle_a(3);
    endtask

    task automatic test_priority();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL prio_alu_stall: got %0b want 0", a_stall); end
        tick();
        checks++; if (a_sel !== 4'b0001) begin errors++; $display("FAIL prio_alu_sel: got %b want 0001", a_sel); end
        idle_a(3);
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL prio_load_stall: got %0b want 1", a_stall); end
        tick();
        tick();
        checks++; if (a_sel !== 4'b0010) begin errors++; $display("FAIL prio_load_sel: got %b want 0010", a_sel); end
        checks++; if (a_cnt !== 16'd2) begin errors++; $display("FAIL prio_cnt: got %0d want 2", a_cnt); end
        idle_a(3);
    endtask

    task automatic test_zero_unused();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %0b want 0", a_stall); end
        tick();
        checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL r0_sel: got %b want 0000", a_sel); end
        checks++; if (a_exv !== 1'b1) begin errors++; $display("FAIL r0_exv: got %0b want 1", a_exv); end
        idle_a(3);
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd9, 5'd4, 2'b01, 5'd0, 1'b0, 1'b0);
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL unused_stall: got %0b want 0", a_stall); end
        tick();
        checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL unused_sel: got %b want 0000", a_sel); end
        idle_a(3);
    endtask

    task automatic test_hold();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        a_hold = 1'b1;
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL hold_stall0: got %0b want 1", a_stall); end
        tick();
        tick();
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL hold_stall2: got %0b want 1", a_stall); end
        checks++; if (a_cnt !== 16'd2) begin errors++; $display("FAIL hold_cnt: got %0d want 2", a_cnt); end
        checks++; if (a_exv !== 1'b1) begin errors++; $display("FAIL hold_exv: got %0b want 1", a_exv); end
        a_hold = 1'b0;
        tick();
        checks++; if (a_cnt !== 16'd3) begin errors++; $display("FAIL hold_rel_cnt: got %0d want 3", a_cnt); end
        checks++; if (a_exv !== 1'b0) begin errors++; $display("FAIL hold_rel_exv: got %0b want 0", a_exv); end
        tick();
        checks++; if (a_sel !== 4'b0010) begin errors++; $display("FAIL hold_rel_sel: got %b want 0010", a_sel); end
        idle_a(3);
    endtask

    task automatic test_flush();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        a_flush = 1'b1;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", a_stall); end
        tick();
        checks++; if (a_exv !== 1'b0) begin errors++; $display("FAIL flush_exv: got %0b want 0", a_exv); end
        a_flush = 1'b0;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall: got %0b want 0", a_stall); end
        tick();
        checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL flush_after_sel: got %b want 0000", a_sel); end
        checks++; if (a_exv !== 1'b1) begin errors++; $display("FAIL flush_after_exv: got %0b want 1", a_exv); end
        checks++; if (a_cnt !== 16'd3) begin errors++; $display("FAIL flush_cnt: got %0d want 3", a_cnt); end
        idle_a(3);
    endtask

    task automatic test_deep_load();
        drive_b(1'b1, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
        tick();
        drive_b(1'b1, 5'd5, 2'b01, 5'd0, 1'b0, 1'b0);
        #1;
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL deep_stall1: got %0b want 1", b_stall); end
        tick();
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL deep_stall2: got %0b want 1", b_stall); end
        tick();
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL deep_stall3: got %0b want 0", b_stall); end
        checks++; if (b_cnt !== 2'd2) begin errors++; $display("FAIL deep_cnt: got %0d want 2", b_cnt); end
        tick();
        checks++; if (b_sel !== 4'b0011) begin errors++; $display("FAIL deep_sel: got %b want 0011", b_sel); end
        checks++; if (b_exv !== 1'b1) begin errors++; $display("FAIL deep_exv: got %0b want 1", b_exv); end
        idle_b(4);
        drive_b(1'b1, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1);
        tick();
        drive_b(1'b1, 5'd6, 2'b01, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checks++; if (b_cnt !== 2'd3) begin errors++; $display("FAIL deep_sat_cnt: got %0d want 3", b_cnt); end
        idle_b(2);
    endtask

    task automatic test_async_reset();
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        tick();
        checks++; if (a_sel !== 4'b0001) begin errors++; $display("FAIL arst_pre_sel: got %b want 0001", a_sel); end
        drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (a_sel !== 4'b0000) begin errors++; $display("FAIL arst_sel: got %b want 0000", a_sel); end
        checks++; if (a_exv !== 1'b0) begin errors++; $display("FAIL arst_exv: got %0b want 0", a_exv); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL arst_cnt: got %0d want 0", a_cnt); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL arst_stall: got %0b want 0", a_stall); end
        tick();
        rst = 1'b0;
        idle_a(2);
    endtask

    initial begin
        a_hold = 1'b0; a_flush = 1'b0;
        b_hold = 1'b0; b_flush = 1'b0;
        drive_b(1'b0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_alu_b2b();
        test_distance();
        test_load_use();
        test_priority();
        test_zero_unused();
        test_hold();
        test_flush();
        test_deep_load();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
